imm_gen_pipe: RTL and testbench

- Pipelined, parametrised immediate generator for the decode stage of the pipelined RISC-V core.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake.
- Emits the XLEN-wide sign-extended immediate, a format code and an illegal flag one cycle later.
- Includes a skid buffer so `in_ready` is a registered signal, plus a saturating illegal-opcode counter for debug.

---
 rtl/imm_gen_pipe_if.sv | 28 ++
 rtl/imm_gen_pipe.sv | 231 +++++++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: valid/ready input and output channels of the immediate
// generator plus the debug illegal-instruction counter.
// master = instruction producer / result consumer, slave = imm_gen_pipe.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_ir;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [31:0]      out_ir;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output in_valid, in_ir, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_ir, illegal_cnt
    );

    modport slave (
        input  in_valid, in_ir, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_ir, illegal_cnt
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator for the decode stage.
// One instruction per cycle in, sign-extended immediate + format code +
// illegal flag out one cycle later. A one-entry skid register keeps in_ready
// a pure flop output. A saturating counter tallies accepted illegal words.
// Optional feature macro: ZICSR_UIMM_EN (CSR*I instructions report fmt 6 with
// the zero-extended 5-bit uimm instead of the I-immediate).
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    imm_gen_pipe_if.slave bus
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_Z   = 3'd6;
    localparam logic [2:0] FMT_ILL = 3'd7;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } skid_state_t;

    // Every immediate is first built as a 32-bit value; widening to XLEN
    // replicates bit 31 (the Z uimm has bit 31 clear, so it zero-extends).
    function automatic logic [XLEN-1:0] sext_xlen(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    logic [31:0]      w_ir;
    logic [31:0]      w_imm32;
    logic [XLEN-1:0]  w_imm;
    logic [2:0]       w_fmt;
    logic             w_illegal;
    logic             w_in_xfer;
    logic             w_out_xfer;

    skid_state_t      r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_imm;
    logic [2:0]       r_out_fmt;
    logic             r_out_illegal;
    logic [31:0]      r_out_ir;
    logic [XLEN-1:0]  r_skid_imm;
    logic [2:0]       r_skid_fmt;
    logic             r_skid_illegal;
    logic [31:0]      r_skid_ir;
    logic [CNT_W-1:0] r_illegal_cnt;

    assign w_ir       = bus.in_ir;
    assign w_in_xfer  = bus.in_valid && r_in_ready;
    assign w_out_xfer = r_out_valid && bus.out_ready;

    // Opcode decode: pick the immediate layout and format for the incoming word.
    always_comb begin
        w_imm32   = 32'd0;
        w_fmt     = FMT_R;
        w_illegal = 1'b0;
        case (w_ir[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_FENCE: begin
                w_imm32 = {{20{w_ir[31]}}, w_ir[31:20]};
                w_fmt   = FMT_I;
            end
            OP_SYSTEM: begin
`ifdef ZICSR_UIMM_EN
                if (w_ir[14]) begin
                    w_imm32 = {27'd0, w_ir[19:15]};
                    w_fmt   = FMT_Z;
                end else begin
                    w_imm32 = {{20{w_ir[31]}}, w_ir[31:20]};
                    w_fmt   = FMT_I;
                end
`else
                w_imm32 = {{20{w_ir[31]}}, w_ir[31:20]};
                w_fmt   = FMT_I;
`endif
            end
            OP_STORE: begin
                w_imm32 = {{20{w_ir[31]}}, w_ir[31:25], w_ir[11:7]};
                w_fmt   = FMT_S;
            end
            OP_BRANCH: begin
                w_imm32 = {{20{w_ir[31]}}, w_ir[7], w_ir[30:25], w_ir[11:8], 1'b0};
                w_fmt   = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                w_imm32 = {w_ir[31:12], 12'd0};
                w_fmt   = FMT_U;
            end
            OP_JAL: begin
                w_imm32 = {{12{w_ir[31]}}, w_ir[19:12], w_ir[20], w_ir[30:21], 1'b0};
                w_fmt   = FMT_J;
            end
            OP_REG: begin
                w_imm32 = 32'd0;
                w_fmt   = FMT_R;
            end
            OP_IMM32: begin
                // RV64-only word-sized arithmetic; unknown opcode on RV32.
                if (XLEN == 64) begin
                    w_imm32 = {{20{w_ir[31]}}, w_ir[31:20]};
                    w_fmt   = FMT_I;
                end else begin
                    w_imm32   = 32'd0;
                    w_fmt     = FMT_ILL;
                    w_illegal = 1'b1;
                end
            end
            OP_REG32: begin
                if (XLEN == 64) begin
                    w_imm32 = 32'd0;
                    w_fmt   = FMT_R;
                end else begin
                    w_imm32   = 32'd0;
                    w_fmt     = FMT_ILL;
                    w_illegal = 1'b1;
                end
            end
            default: begin
                // Also covers every word whose low two bits are not 2'b11.
                w_imm32   = 32'd0;
                w_fmt     = FMT_ILL;
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_imm = sext_xlen(w_imm32);

    // Skid FSM: output register takes new items directly unless it is stalled,
    // in which case the item parks in the skid register and in_ready drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_EMPTY;
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_out_imm      <= '0;
            r_out_fmt      <= 3'd0;
            r_out_illegal  <= 1'b0;
            r_out_ir       <= 32'd0;
            r_skid_imm     <= '0;
            r_skid_fmt     <= 3'd0;
            r_skid_illegal <= 1'b0;
            r_skid_ir      <= 32'd0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        if (!r_out_valid || bus.out_ready) begin
                            r_out_valid   <= 1'b1;
                            r_out_imm     <= w_imm;
                            r_out_fmt     <= w_fmt;
                            r_out_illegal <= w_illegal;
                            r_out_ir      <= w_ir;
                        end else begin
                            r_skid_imm     <= w_imm;
                            r_skid_fmt     <= w_fmt;
                            r_skid_illegal <= w_illegal;
                            r_skid_ir      <= w_ir;
                            r_state        <= ST_FULL;
                            r_in_ready     <= 1'b0;
                        end
                    end else if (w_out_xfer) begin
                        r_out_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so the only event is the drain.
                    if (bus.out_ready) begin
                        r_out_valid   <= 1'b1;
                        r_out_imm     <= r_skid_imm;
                        r_out_fmt     <= r_skid_fmt;
                        r_out_illegal <= r_skid_illegal;
                        r_out_ir      <= r_skid_ir;
                        r_state       <= ST_EMPTY;
                        r_in_ready    <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Debug tally of accepted illegal instructions; sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal_cnt <= '0;
        end else if (w_in_xfer && w_illegal && (r_illegal_cnt != CNT_MAX)) begin
            r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_imm     = r_out_imm;
    assign bus.out_fmt     = r_out_fmt;
    assign bus.out_illegal = r_out_illegal;
    assign bus.out_ir      = r_out_ir;
    assign bus.illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives an RV32 (CNT_W=16) and an RV64 (CNT_W=2) instance
// in lockstep with identical stimulus; directed scenarios plus a randomized
// run checked against a behavioural decode/queue model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_ir = 32'd0;
    logic        out_ready = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    imm_gen_pipe_if #(.XLEN(32), .CNT_W(16)) if32 ();
    imm_gen_pipe_if #(.XLEN(64), .CNT_W(2))  if64 ();

    assign if32.in_valid  = in_valid;
    assign if32.in_ir     = in_ir;
    assign if32.out_ready = out_ready;
    assign if64.in_valid  = in_valid;
    assign if64.in_ir     = in_ir;
    assign if64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .CNT_W(16)) u_dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
    imm_gen_pipe #(.XLEN(64), .CNT_W(2))  u_dut64 (.clk(clk), .rst(rst), .bus(if64.slave));

    always #5 clk = ~clk;

    // Reference decode written from the ISA field definitions.
    function automatic void ref_decode(input logic [31:0] ir, input bit x64,
                                       output logic [63:0] imm, output logic [2:0] fmt,
                                       output logic ill);
        longint v;
        v = 0; fmt = 3'd7; ill = 1'b1;
        case (ir[6:0])
            7'h13, 7'h03, 7'h67, 7'h0F: begin v = longint'($signed(ir[31:20])); fmt = 3'd1; ill = 1'b0; end
            7'h73: begin
`ifdef ZICSR_UIMM_EN
                if (ir[14]) begin v = longint'(ir[19:15]); fmt = 3'd6; end
                else begin v = longint'($signed(ir[31:20])); fmt = 3'd1; end
`else
                v = longint'($signed(ir[31:20])); fmt = 3'd1;
`endif
                ill = 1'b0;
            end
            7'h23: begin v = longint'($signed({ir[31:25], ir[11:7]})); fmt = 3'd2; ill = 1'b0; end
            7'h63: begin v = longint'($signed({ir[31], ir[7], ir[30:25], ir[11:8]})) * longint'(2); fmt = 3'd3; ill = 1'b0; end
            7'h37, 7'h17: begin v = longint'($signed(ir[31:12])) * longint'(4096); fmt = 3'd4; ill = 1'b0; end
            7'h6F: begin v = longint'($signed({ir[31], ir[19:12], ir[20], ir[30:21]})) * longint'(2); fmt = 3'd5; ill = 1'b0; end
            7'h33: begin v = 0; fmt = 3'd0; ill = 1'b0; end
            7'h1B: if (x64) begin v = longint'($signed(ir[31:20])); fmt = 3'd1; ill = 1'b0; end
            7'h3B: if (x64) begin v = 0; fmt = 3'd0; ill = 1'b0; end
            default: ;
        endcase
        imm = v;
    endfunction

    function automatic logic [67:0] exp32(input logic [31:0] ir);
        logic [63:0] imm; logic [2:0] f; logic il;
        ref_decode(ir, 1'b0, imm, f, il);
        return {f, il, imm[31:0], ir};
    endfunction

    function automatic logic [99:0] exp64(input logic [31:0] ir);
        logic [63:0] imm; logic [2:0] f; logic il;
        ref_decode(ir, 1'b1, imm, f, il);
        return {f, il, imm, ir};
    endfunction

    function automatic bit is_ill(input logic [31:0] ir, input bit x64);
        logic [63:0] imm; logic [2:0] f; logic il;
        ref_decode(ir, x64, imm, f, il);
        return il;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if ({if32.out_valid, if32.in_ready, if32.out_fmt, if32.out_illegal, if32.out_imm, if32.out_ir, if32.illegal_cnt}
            !== {1'b1 == 1'b0, 1'b1, 3'd0, 1'b0, 32'd0, 32'd0, 16'd0}) begin
            n_err++;
            $display("FAIL reset32 got v=%b r=%b f=%0d il=%b imm=%h ir=%h cnt=%0d want v=0 r=1 zeros",
                     if32.out_valid, if32.in_ready, if32.out_fmt, if32.out_illegal, if32.out_imm, if32.out_ir, if32.illegal_cnt);
        end
        n_vec++;
        if ({if64.out_valid, if64.in_ready, if64.out_fmt, if64.out_illegal, if64.out_imm, if64.out_ir, if64.illegal_cnt}
            !== {1'b0, 1'b1, 3'd0, 1'b0, 64'd0, 32'd0, 2'd0}) begin
            n_err++;
            $display("FAIL reset64 got v=%b r=%b f=%0d il=%b imm=%h cnt=%0d want v=0 r=1 zeros",
                     if64.out_valid, if64.in_ready, if64.out_fmt, if64.out_illegal, if64.out_imm, if64.illegal_cnt);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        in_ir = 32'hFFF00093; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if ({if32.out_valid, if32.out_fmt, if32.out_illegal, if32.out_imm} !== {1'b1, 3'd1, 1'b0, 32'hFFFFFFFF}) begin
            n_err++;
            $display("FAIL addi32 got v=%b f=%0d il=%b imm=%h want 1/1/0/ffffffff",
                     if32.out_valid, if32.out_fmt, if32.out_illegal, if32.out_imm);
        end
        n_vec++;
        if ({if64.out_valid, if64.out_fmt, if64.out_illegal, if64.out_imm} !== {1'b1, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF}) begin
            n_err++;
            $display("FAIL addi64 got v=%b f=%0d il=%b imm=%h want all-ones", if64.out_valid, if64.out_fmt, if64.out_illegal, if64.out_imm);
        end
        tick();
        n_vec++;
        if ({if32.out_valid, if64.out_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL addi_drain got valid=%b%b want 00", if32.out_valid, if64.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] irs [3];
        logic [31:0] i32 [3];
        logic [2:0]  fm  [3];
        irs = '{32'h123450B7, 32'hFE000EE3, 32'hFFDFF06F};
        i32 = '{32'h12345000, 32'hFFFFFFFC, 32'hFFFFFFFC};
        fm  = '{3'd4, 3'd3, 3'd5};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_ir = irs[i]; in_valid = 1'b1;
            tick();
            n_vec++;
            if ({if32.out_valid, if32.out_fmt, if32.out_imm, if32.out_ir} !== {1'b1, fm[i], i32[i], irs[i]}) begin
                n_err++;
                $display("FAIL b2b32[%0d] got v=%b f=%0d imm=%h ir=%h want f=%0d imm=%h", i,
                         if32.out_valid, if32.out_fmt, if32.out_imm, if32.out_ir, fm[i], i32[i]);
            end
            n_vec++;
            if ({if64.out_valid, if64.out_fmt, if64.out_imm} !== {1'b1, fm[i], {{32{i32[i][31]}}, i32[i]}}) begin
                n_err++;
                $display("FAIL b2b64[%0d] got v=%b f=%0d imm=%h", i, if64.out_valid, if64.out_fmt, if64.out_imm);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, c;
        a = 32'h00500093; b = 32'h123450B7; c = 32'hFE000EE3;
        out_ready = 1'b0;
        in_ir = a; in_valid = 1'b1;
        tick();
        n_vec++;
        if ({if32.in_ready, if32.out_valid, if32.out_imm, if32.out_ir} !== {1'b1, 1'b1, 32'd5, a}) begin
            n_err++;
            $display("FAIL bp_c1 got rdy=%b v=%b imm=%h ir=%h want rdy=1 A", if32.in_ready, if32.out_valid, if32.out_imm, if32.out_ir);
        end
        in_ir = b;
        tick();
        in_ir = c;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if ({if32.in_ready, if64.in_ready, if32.out_valid, if32.out_imm, if32.out_ir} !== {1'b0, 1'b0, 1'b1, 32'd5, a}) begin
                n_err++;
                $display("FAIL bp_hold[%0d] got rdy=%b%b v=%b imm=%h ir=%h want rdy=00 A held", k,
                         if32.in_ready, if64.in_ready, if32.out_valid, if32.out_imm, if32.out_ir);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if ({if32.in_ready, if32.out_valid, if32.out_fmt, if32.out_imm, if32.out_ir} !== {1'b1, 1'b1, 3'd4, 32'h12345000, b}) begin
            n_err++;
            $display("FAIL bp_rel_b got rdy=%b v=%b f=%0d imm=%h ir=%h want B", if32.in_ready, if32.out_valid, if32.out_fmt, if32.out_imm, if32.out_ir);
        end
        tick();
        in_valid = 1'b0;
        n_vec++;
        if ({if32.out_valid, if32.out_fmt, if32.out_imm, if32.out_ir} !== {1'b1, 3'd3, 32'hFFFFFFFC, c}) begin
            n_err++;
            $display("FAIL bp_rel_c got v=%b f=%0d imm=%h ir=%h want C", if32.out_valid, if32.out_fmt, if32.out_imm, if32.out_ir);
        end
        tick();
        n_vec++;
        if ({if32.out_valid, if64.out_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL bp_empty got valid=%b%b want 00", if32.out_valid, if64.out_valid);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] irs [5];
        irs = '{32'h00000000, 32'hFFFFFFFF, 32'h0000007F, 32'h12345678, 32'h00000002};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_ir = irs[i]; in_valid = 1'b1;
            tick();
            n_vec++;
            if ({if32.out_fmt, if32.out_illegal, if32.out_imm, if64.out_fmt, if64.out_illegal, if64.out_imm}
                !== {3'd7, 1'b1, 32'd0, 3'd7, 1'b1, 64'd0}) begin
                n_err++;
                $display("FAIL illegal[%0d] got f=%0d/%0d il=%b/%b imm=%h want 7/1/0", i,
                         if32.out_fmt, if64.out_fmt, if32.out_illegal, if64.out_illegal, if32.out_imm);
            end
            if (i == 1) begin
                n_vec++;
                if ({if32.illegal_cnt, if64.illegal_cnt} !== {16'd2, 2'd2}) begin
                    n_err++;
                    $display("FAIL illcnt2 got %0d/%0d want 2/2", if32.illegal_cnt, if64.illegal_cnt);
                end
            end
        end
        in_valid = 1'b0;
        tick();
        n_vec++;
        if ({if32.illegal_cnt, if64.illegal_cnt} !== {16'd5, 2'd3}) begin
            n_err++;
            $display("FAIL illcnt_sat got %0d/%0d want 5/3", if32.illegal_cnt, if64.illegal_cnt);
        end
    endtask

    task automatic test_xlen64();
        logic [31:0]  irs [3];
        logic [35:0]  e32 [3];
        logic [67:0]  e64 [3];
        irs = '{32'h800000B7, 32'h0010009B, 32'h00B5053B};
        e32 = '{{3'd4, 1'b0, 32'h80000000}, {3'd7, 1'b1, 32'd0}, {3'd7, 1'b1, 32'd0}};
        e64 = '{{3'd4, 1'b0, 64'hFFFFFFFF80000000}, {3'd1, 1'b0, 64'd1}, {3'd0, 1'b0, 64'd0}};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_ir = irs[i]; in_valid = 1'b1;
            tick();
            n_vec++;
            if ({if32.out_fmt, if32.out_illegal, if32.out_imm} !== e32[i]) begin
                n_err++;
                $display("FAIL x64_rv32[%0d] got %h want %h", i, {if32.out_fmt, if32.out_illegal, if32.out_imm}, e32[i]);
            end
            n_vec++;
            if ({if64.out_fmt, if64.out_illegal, if64.out_imm} !== e64[i]) begin
                n_err++;
                $display("FAIL x64_rv64[%0d] got %h want %h", i, {if64.out_fmt, if64.out_illegal, if64.out_imm}, e64[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        n_vec++;
        if ({if32.illegal_cnt, if64.illegal_cnt} !== {16'd7, 2'd3}) begin
            n_err++;
            $display("FAIL x64_cnt got %0d/%0d want 7/3", if32.illegal_cnt, if64.illegal_cnt);
        end
    endtask

    task automatic test_csr();
        logic [35:0] want;
`ifdef ZICSR_UIMM_EN
        want = {3'd6, 1'b0, 32'd3};
`else
        want = {3'd1, 1'b0, 32'h00000340};
`endif
        out_ready = 1'b1;
        in_ir = 32'h3401D073; in_valid = 1'b1;
        tick();
        n_vec++;
        if ({if32.out_fmt, if32.out_illegal, if32.out_imm} !== want) begin
            n_err++;
            $display("FAIL csrrwi got %h want %h", {if32.out_fmt, if32.out_illegal, if32.out_imm}, want);
        end
        in_ir = 32'h00000073;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if ({if32.out_fmt, if32.out_illegal, if32.out_imm, if64.out_fmt, if64.out_imm} !== {3'd1, 1'b0, 32'd0, 3'd1, 64'd0}) begin
            n_err++;
            $display("FAIL ecall got f=%0d/%0d imm=%h want 1/1/0", if32.out_fmt, if64.out_fmt, if32.out_imm);
        end
        tick();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        out_ready = 1'b0;
        in_ir = 32'hFFFFFFFF; in_valid = 1'b1;
        tick();
        in_ir = 32'h00500093;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if ({if32.in_ready, if32.out_valid, if32.illegal_cnt} !== {1'b0, 1'b1, 16'd1}) begin
            n_err++;
            $display("FAIL mid_full got rdy=%b v=%b cnt=%0d want 0/1/1", if32.in_ready, if32.out_valid, if32.illegal_cnt);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({if32.out_valid, if32.in_ready, if32.illegal_cnt, if32.out_imm, if64.out_valid, if64.in_ready, if64.illegal_cnt}
            !== {1'b0, 1'b1, 16'd0, 32'd0, 1'b0, 1'b1, 2'd0}) begin
            n_err++;
            $display("FAIL mid_rst got v=%b r=%b cnt=%0d imm=%h / v=%b r=%b cnt=%0d want 0/1/0",
                     if32.out_valid, if32.in_ready, if32.illegal_cnt, if32.out_imm,
                     if64.out_valid, if64.in_ready, if64.illegal_cnt);
        end
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_vec++;
        if ({if32.out_valid, if64.out_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL mid_after got valid=%b%b want 00", if32.out_valid, if64.out_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] q [$];
        logic [15:0] c32;
        logic [1:0]  c64;
        logic [31:0] r;
        logic [6:0]  ops [13];
        bit          in_x, out_x;
        ops = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h1B, 7'h3B};
        c32 = 16'd0; c64 = 2'd0;
        do_reset();
        for (int cyc = 0; cyc < 420; cyc++) begin
            if (cyc < 400) begin
                int k;
                k = int'($urandom_range(0, 13));
                r = $urandom();
                in_ir     = (k == 13) ? r : {r[31:7], ops[k]};
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 4) < 3);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            @(negedge clk);
            n_vec++;
            if ({if32.in_ready, if32.out_valid, if32.illegal_cnt, if64.in_ready, if64.out_valid, if64.illegal_cnt}
                !== {q.size() < 2, q.size() > 0, c32, q.size() < 2, q.size() > 0, c64}) begin
                n_err++;
                $display("FAIL rnd_ctl cyc=%0d got rdy=%b%b v=%b%b cnt=%0d/%0d want occ=%0d cnt=%0d/%0d", cyc,
                         if32.in_ready, if64.in_ready, if32.out_valid, if64.out_valid,
                         if32.illegal_cnt, if64.illegal_cnt, q.size(), c32, c64);
            end
            if (q.size() > 0) begin
                n_vec++;
                if ({if32.out_fmt, if32.out_illegal, if32.out_imm, if32.out_ir} !== exp32(q[0])) begin
                    n_err++;
                    $display("FAIL rnd_p32 cyc=%0d got %h want %h", cyc,
                             {if32.out_fmt, if32.out_illegal, if32.out_imm, if32.out_ir}, exp32(q[0]));
                end
                n_vec++;
                if ({if64.out_fmt, if64.out_illegal, if64.out_imm, if64.out_ir} !== exp64(q[0])) begin
                    n_err++;
                    $display("FAIL rnd_p64 cyc=%0d got %h want %h", cyc,
                             {if64.out_fmt, if64.out_illegal, if64.out_imm, if64.out_ir}, exp64(q[0]));
                end
            end
            in_x  = in_valid && (q.size() < 2);
            out_x = (q.size() > 0) && out_ready;
            if (out_x) void'(q.pop_front());
            if (in_x) begin
                q.push_back(in_ir);
                if (is_ill(in_ir, 1'b0) && c32 != 16'hFFFF) c32 = c32 + 16'd1;
                if (is_ill(in_ir, 1'b1) && c64 != 2'd3)     c64 = c64 + 2'd1;
            end
            @(posedge clk);
            #1;
        end
        n_vec++;
        if (q.size() != 0 || if32.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rnd_drain got occ=%0d v=%b want 0/0", q.size(), if32.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_xlen64();
        test_csr();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
